// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the intersection controllers.
// Pure declarations; no latency or backpressure.
// Durations are in core clock cycles at 50 MHz.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RED,
        WALK,
        CLEAR,
        FAULT
    } ped_state_t;

    localparam int unsigned DEF_WALK_CYCLES       = 32'd350000000;
    localparam int unsigned DEF_CLEAR_CYCLES      = 32'd250000000;
    localparam int unsigned DEF_FLASH_HALF_CYCLES = 32'd25000000;
    localparam int unsigned DEF_CHIRP_HALF_CYCLES = 32'd12500000;
    localparam int unsigned DEF_CNT_W             = 32'd32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk edges. No backpressure.
// Resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/ped_signal.sv
// Pedestrian WALK/DON'T-WALK controller slaved to the vehicle lamps, with conflict monitor.
// Latency: button to req_pending 3 edges; walk rises on the red-onset edge. No backpressure.
// Optional audible cue on port chirp when PED_CHIRP_EN is defined.
module ped_signal
    import traffic_pkg::*;
#(
    parameter int unsigned WALK_CYCLES       = DEF_WALK_CYCLES,
    parameter int unsigned CLEAR_CYCLES      = DEF_CLEAR_CYCLES,
    parameter int unsigned FLASH_HALF_CYCLES = DEF_FLASH_HALF_CYCLES,
`ifdef PED_CHIRP_EN
    parameter int unsigned CHIRP_HALF_CYCLES = DEF_CHIRP_HALF_CYCLES,
`endif
    parameter int unsigned CNT_W             = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic red,
    input  logic yellow,
    input  logic green,
    input  logic ped_button,
    input  logic fault_clr,
    output logic walk,
    output logic dont_walk,
    output logic req_pending,
    output logic fault
`ifdef PED_CHIRP_EN
    ,
    output logic chirp
`endif
);

    logic             w_btn_sync;
    logic             w_red_rise;
    logic [1:0]       w_lamp_cnt;
    logic             w_one_hot;
    logic             w_conflict;
    logic             w_start;

    ped_state_t       r_state;
    logic             r_red_q;
    logic             r_armed;
    logic             r_req;
    logic             r_walk;
    logic             r_dont_walk;
    logic             r_fault;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_flash_cnt;

    sync_2ff u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ped_button),
        .q     (w_btn_sync)
    );

    assign w_red_rise = red & ~r_red_q;
    assign w_lamp_cnt = {1'b0, red} + {1'b0, yellow} + {1'b0, green};
    assign w_one_hot  = (w_lamp_cnt == 2'd1);
    // Lamp checks stay off until the light has shown one valid aspect after reset.
    assign w_conflict = r_armed &&
                        (!w_one_hot || (((r_state == WALK) || (r_state == CLEAR)) && !red));
    assign w_start    = w_red_rise && ((r_state == WAIT_RED) || ((r_state == IDLE) && r_req));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_red_q     <= 1'b0;
            r_armed     <= 1'b0;
            r_req       <= 1'b0;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
            r_fault     <= 1'b0;
            r_cnt       <= '0;
            r_flash_cnt <= '0;
        end else begin
            r_red_q <= red;
            if (w_one_hot) begin
                r_armed <= 1'b1;
            end

            if (w_conflict) begin
                r_state     <= FAULT;
                r_walk      <= 1'b0;
                r_dont_walk <= 1'b1;
                r_fault     <= 1'b1;
            end else if (w_start) begin
                r_state     <= WALK;
                r_cnt       <= CNT_W'(WALK_CYCLES - 1);
                r_req       <= 1'b0;
                r_walk      <= 1'b1;
                r_dont_walk <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_req) begin
                            r_state <= WAIT_RED;
                        end
                    end
                    WAIT_RED: begin
                    end
                    WALK: begin
                        if (r_cnt == '0) begin
                            r_state     <= CLEAR;
                            r_cnt       <= CNT_W'(CLEAR_CYCLES - 1);
                            r_flash_cnt <= CNT_W'(FLASH_HALF_CYCLES - 1);
                            r_walk      <= 1'b0;
                            r_dont_walk <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    CLEAR: begin
                        if (r_cnt == '0) begin
                            r_state     <= r_req ? WAIT_RED : IDLE;
                            r_dont_walk <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                            if (r_flash_cnt == '0) begin
                                r_flash_cnt <= CNT_W'(FLASH_HALF_CYCLES - 1);
                                r_dont_walk <= ~r_dont_walk;
                            end else begin
                                r_flash_cnt <= r_flash_cnt - 1'b1;
                            end
                        end
                    end
                    FAULT: begin
                        if (fault_clr) begin
                            r_state <= IDLE;
                            r_fault <= 1'b0;
                            r_req   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end

            // A held or fresh request always survives a same-edge clear.
            if (w_btn_sync) begin
                r_req <= 1'b1;
            end
        end
    end

    assign walk        = r_walk;
    assign dont_walk   = r_dont_walk;
    assign req_pending = r_req;
    assign fault       = r_fault;

`ifdef PED_CHIRP_EN
    logic             r_chirp;
    logic [CNT_W-1:0] r_chirp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chirp     <= 1'b0;
            r_chirp_cnt <= '0;
        end else if (w_conflict) begin
            r_chirp <= 1'b0;
        end else if (w_start) begin
            r_chirp     <= 1'b1;
            r_chirp_cnt <= CNT_W'(CHIRP_HALF_CYCLES - 1);
        end else if ((r_state == WALK) && (r_cnt != '0)) begin
            if (r_chirp_cnt == '0) begin
                r_chirp     <= ~r_chirp;
                r_chirp_cnt <= CNT_W'(CHIRP_HALF_CYCLES - 1);
            end else begin
                r_chirp_cnt <= r_chirp_cnt - 1'b1;
            end
        end else begin
            r_chirp <= 1'b0;
        end
    end

    assign chirp = r_chirp;
`endif

endmodule
